// File: rtl/ex_alu_stage_pkg.sv
// Shared constants for the execute-stage ALU: op encodings, op classes,
// funct codes and forwarding selects, plus the signed-overflow helper.
package ex_alu_stage_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_IMM   = 2'b11;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_ZERO = 2'b11;

  // Subtraction overflows when the operand signs differ; addition when they match.
  function automatic logic signed_ovf(input logic a_sign, input logic b_sign,
                                      input logic r_sign, input logic is_sub);
    logic same_s;
    same_s = (a_sign == b_sign);
    signed_ovf = (is_sub ? !same_s : same_s) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/ex_alu_stage_fwd_mux4.sv
// 4:1 operand forwarding multiplexer; select 11 yields zero.
module fwd_mux4
  import ex_alu_stage_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] reg_val,
  input  logic [31:0] wb_val,
  input  logic [31:0] mem_val,
  output logic [31:0] out_val
);

  // Forwarding source selection
  always_comb begin
    out_val = 32'h0;
    case (sel)
      FWD_REG:  out_val = reg_val;
      FWD_WB:   out_val = wb_val;
      FWD_MEM:  out_val = mem_val;
      FWD_ZERO: out_val = 32'h0;
      default:  out_val = 32'h0;
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: operand forwarding, ALU op decode, 32-bit ALU with signed
// overflow, and the EX/MEM output registers.
module ex_alu_stage
  import ex_alu_stage_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        en,
  input  logic [1:0]  forward_a,
  input  logic [1:0]  forward_b,
  input  logic [31:0] reg_a,
  input  logic [31:0] reg_b,
  input  logic [31:0] wb_data,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] imm_value,
  input  logic        alu_src,
  input  logic [1:0]  aluop,
  input  logic        andi,
  input  logic        ori,
  input  logic        addi,
  output logic [3:0]  alu_con,
  output logic [31:0] alu_result,
  output logic [31:0] ex_alu_out,
  output logic [31:0] ex_store_data,
  output logic        ex_overflow
);

  logic [31:0] op_a_s;
  logic [31:0] fwd_b_s;
  logic [31:0] op_b_s;
  logic [5:0]  funct_s;
  logic        ovf_s;
  logic [31:0] ex_alu_out_r;
  logic [31:0] ex_store_data_r;
  logic        ex_overflow_r;

  fwd_mux4 u_fwd_a (
    .sel     (forward_a),
    .reg_val (reg_a),
    .wb_val  (wb_data),
    .mem_val (mem_alu_out),
    .out_val (op_a_s)
  );

  fwd_mux4 u_fwd_b (
    .sel     (forward_b),
    .reg_val (reg_b),
    .wb_val  (wb_data),
    .mem_val (mem_alu_out),
    .out_val (fwd_b_s)
  );

  assign op_b_s  = alu_src ? imm_value : fwd_b_s;
  assign funct_s = imm_value[5:0];

  // ALU operation decode from op class, immediate flags and funct
  always_comb begin
    alu_con = ALU_NOP;
    case (aluop)
      AOP_ADD: alu_con = ALU_ADD;
      AOP_SUB: alu_con = ALU_SUB;
      AOP_IMM: begin
        if (andi) begin
          alu_con = ALU_AND;
        end else if (ori) begin
          alu_con = ALU_OR;
        end else if (addi) begin
          alu_con = ALU_ADD;
        end else begin
          alu_con = ALU_ADD;
        end
      end
      AOP_RTYPE: begin
        case (funct_s)
          F_ADD, F_ADDU: alu_con = ALU_ADD;
          F_SUB, F_SUBU: alu_con = ALU_SUB;
          F_AND:         alu_con = ALU_AND;
          F_OR:          alu_con = ALU_OR;
          F_XOR:         alu_con = ALU_XOR;
          F_NOR:         alu_con = ALU_NOR;
          F_SLT:         alu_con = ALU_SLT;
          default:       alu_con = ALU_NOP;
        endcase
      end
      default: alu_con = ALU_NOP;
    endcase
  end

  // ALU datapath and overflow flag; overflow never suppresses the result
  always_comb begin
    alu_result = 32'h0;
    ovf_s      = 1'b0;
    case (alu_con)
      ALU_AND: alu_result = op_a_s & op_b_s;
      ALU_OR:  alu_result = op_a_s | op_b_s;
      ALU_ADD: begin
        alu_result = op_a_s + op_b_s;
        ovf_s      = signed_ovf(op_a_s[31], op_b_s[31], alu_result[31], 1'b0);
      end
      ALU_SUB: begin
        alu_result = op_a_s - op_b_s;
        ovf_s      = signed_ovf(op_a_s[31], op_b_s[31], alu_result[31], 1'b1);
      end
      ALU_SLT: alu_result = ($signed(op_a_s) < $signed(op_b_s)) ? 32'h1 : 32'h0;
      ALU_XOR: alu_result = op_a_s ^ op_b_s;
      ALU_NOR: alu_result = ~(op_a_s | op_b_s);
      default: alu_result = 32'h0;
    endcase
  end

  // EX/MEM output registers; store data is the forwarded B, never the immediate
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex_alu_out_r    <= 32'h0;
      ex_store_data_r <= 32'h0;
      ex_overflow_r   <= 1'b0;
    end else if (en) begin
      ex_alu_out_r    <= alu_result;
      ex_store_data_r <= fwd_b_s;
      ex_overflow_r   <= ovf_s;
    end else begin
      ex_alu_out_r    <= ex_alu_out_r;
      ex_store_data_r <= ex_store_data_r;
      ex_overflow_r   <= ex_overflow_r;
    end
  end

  assign ex_alu_out    = ex_alu_out_r;
  assign ex_store_data = ex_store_data_r;
  assign ex_overflow   = ex_overflow_r;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed self-checking bench for ex_alu_stage with hand-computed expectations.
module tb_ex_alu_stage;

  logic        clock;
  logic        resetn;
  logic        en;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic [31:0] wb_data;
  logic [31:0] mem_alu_out;
  logic [31:0] imm_value;
  logic        alu_src;
  logic [1:0]  aluop;
  logic        andi;
  logic        ori;
  logic        addi;
  logic [3:0]  alu_con;
  logic [31:0] alu_result;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic        ex_overflow;

  int n_checks;
  int n_failures;

  ex_alu_stage dut (
    .clock         (clock),
    .resetn        (resetn),
    .en            (en),
    .forward_a     (forward_a),
    .forward_b     (forward_b),
    .reg_a         (reg_a),
    .reg_b         (reg_b),
    .wb_data       (wb_data),
    .mem_alu_out   (mem_alu_out),
    .imm_value     (imm_value),
    .alu_src       (alu_src),
    .aluop         (aluop),
    .andi          (andi),
    .ori           (ori),
    .addi          (addi),
    .alu_con       (alu_con),
    .alu_result    (alu_result),
    .ex_alu_out    (ex_alu_out),
    .ex_store_data (ex_store_data),
    .ex_overflow   (ex_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_failures = n_failures + 1;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] e_out,
                            input logic [31:0] e_st, input logic e_ovf);
    check({tag, "_out"}, ex_alu_out, e_out);
    check({tag, "_st"}, ex_store_data, e_st);
    check({tag, "_ovf"}, {31'h0, ex_overflow}, {31'h0, e_ovf});
  endtask

  logic [31:0] exp_fwd [4] = '{32'h1, 32'h2, 32'h3, 32'h0};
  logic [5:0]  rt_funct [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100110, 6'b100111, 6'b101010};
  logic [31:0] rt_res [7] = '{32'd12, 32'd2, 32'd5, 32'd7, 32'd2, 32'hFFFFFFF8, 32'd0};
  logic [3:0]  rt_con [7] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hD, 4'hC, 4'h7};
  logic [2:0]  imm_flags [4] = '{3'b100, 3'b010, 3'b001, 3'b110};
  logic [31:0] imm_res [4] = '{32'h000F, 32'h0FFF, 32'h100E, 32'h000F};
  logic [3:0]  imm_con [4] = '{4'h0, 4'h1, 4'h2, 4'h0};

  initial begin
    n_checks    = 0;
    n_failures  = 0;
    resetn      = 1'b0;
    en          = 1'b0;
    forward_a   = 2'b00;
    forward_b   = 2'b00;
    reg_a       = 32'h0;
    reg_b       = 32'h0;
    wb_data     = 32'h0;
    mem_alu_out = 32'h0;
    imm_value   = 32'h0;
    alu_src     = 1'b0;
    aluop       = 2'b00;
    andi        = 1'b0;
    ori         = 1'b0;
    addi        = 1'b0;
    #2;
    check_regs("reset_init", 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    resetn = 1'b1;

    // Forwarding sweep on operand A
    reg_a = 32'h1; wb_data = 32'h2; mem_alu_out = 32'h3;
    for (int i = 0; i < 4; i++) begin
      forward_a = 2'(i);
      #1;
      check($sformatf("fwd_a%0d", i), alu_result, exp_fwd[i]);
    end
    forward_a = 2'b00;

    // R-type funct sweep
    reg_a = 32'd7; reg_b = 32'd5; aluop = 2'b10;
    for (int i = 0; i < 7; i++) begin
      imm_value = {26'h0, rt_funct[i]};
      #1;
      check($sformatf("rtype_res%0d", i), alu_result, rt_res[i]);
      check($sformatf("rtype_con%0d", i), {28'h0, alu_con}, {28'h0, rt_con[i]});
    end
    imm_value = 32'h0;
    #1;
    check("rtype_nop_con", {28'h0, alu_con}, 32'hF);
    check("rtype_nop_res", alu_result, 32'h0);

    // Immediate ops with flag priority
    aluop = 2'b11; alu_src = 1'b1; reg_a = 32'h0F0F; imm_value = 32'h00FF;
    for (int i = 0; i < 4; i++) begin
      {andi, ori, addi} = imm_flags[i];
      #1;
      check($sformatf("imm_res%0d", i), alu_result, imm_res[i]);
      check($sformatf("imm_con%0d", i), {28'h0, alu_con}, {28'h0, imm_con[i]});
    end
    {andi, ori, addi} = 3'b000;
    alu_src = 1'b0;

    // SLT signedness
    aluop = 2'b10; imm_value = 32'h2A;
    reg_a = 32'hFFFFFFFF; reg_b = 32'h1;
    #1;
    check("slt_neg_lt", alu_result, 32'h1);
    reg_a = 32'h1; reg_b = 32'hFFFFFFFF;
    #1;
    check("slt_pos_ge", alu_result, 32'h0);

    // Overflow through the registers, en=1, one-cycle latency
    @(negedge clock);
    en = 1'b1; aluop = 2'b00; reg_a = 32'h7FFFFFFF; reg_b = 32'h1;
    step();
    check_regs("ovf_add", 32'h80000000, 32'h1, 1'b1);
    @(negedge clock);
    aluop = 2'b01; reg_a = 32'h80000000; reg_b = 32'h1;
    step();
    check_regs("ovf_sub", 32'h7FFFFFFF, 32'h1, 1'b1);
    @(negedge clock);
    aluop = 2'b00; reg_a = 32'hFFFFFFFF; reg_b = 32'h1;
    step();
    check_regs("no_ovf", 32'h0, 32'h1, 1'b0);

    // Store data keeps forwarded B even with immediate B operand
    @(negedge clock);
    reg_a = 32'h10; reg_b = 32'h55; imm_value = 32'h100; alu_src = 1'b1;
    step();
    check_regs("store_b", 32'h110, 32'h55, 1'b0);

    // en=0 holds
    @(negedge clock);
    en = 1'b0; reg_a = 32'h7FFFFFFF; reg_b = 32'h99; imm_value = 32'h1;
    step();
    step();
    check_regs("hold", 32'h110, 32'h55, 1'b0);

    // Async reset mid-cycle with en=1 asserted: reset wins, no edge needed
    en = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check_regs("async_rst", 32'h0, 32'h0, 1'b0);
    step();
    check_regs("rst_vs_en", 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    step();
    check_regs("post_rst", 32'h80000000, 32'h99, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
